// File: rtl/ps2_pkg.sv
// ps2_pkg
// Shared definitions for the PS/2 key controller: scan-code constants,
// key bit indices, FSM state encodings and the scan-code to key-bit map.
package ps2_pkg;

  localparam logic [7:0] SC_EXT         = 8'hE0;
  localparam logic [7:0] SC_BREAK       = 8'hF0;
  localparam logic [7:0] SC_NUL         = 8'h00;
  localparam logic [7:0] SC_OVERRUN     = 8'hFF;

  localparam logic [7:0] SC_P1_UP       = 8'h75;
  localparam logic [7:0] SC_P1_LEFT     = 8'h6B;
  localparam logic [7:0] SC_P1_RIGHT    = 8'h74;
  localparam logic [7:0] SC_P1_DOWN     = 8'h72;
  localparam logic [7:0] SC_P1_SHOOT    = 8'h29;

  localparam logic [7:0] SC_P2_UP       = 8'h1D;
  localparam logic [7:0] SC_P2_LEFT     = 8'h1C;
  localparam logic [7:0] SC_P2_RIGHT    = 8'h23;
  localparam logic [7:0] SC_P2_DOWN     = 8'h1B;
  localparam logic [7:0] SC_P2_SHOOT    = 8'h0D;

  localparam int unsigned NUM_KEYS = 5;

  localparam logic [2:0] KEY_UP    = 3'd0;
  localparam logic [2:0] KEY_LEFT  = 3'd1;
  localparam logic [2:0] KEY_RIGHT = 3'd2;
  localparam logic [2:0] KEY_DOWN  = 3'd3;
  localparam logic [2:0] KEY_SHOOT = 3'd4;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_e;

  typedef enum logic [1:0] {
    D_IDLE,
    D_EXT,
    D_BREAK,
    D_EXT_BREAK
  } dec_state_e;

  // hit: code is one of the ten game keys; p2: belongs to player 2
  typedef struct packed {
    logic       hit;
    logic       p2;
    logic [2:0] idx;
  } key_map_t;

  function automatic key_map_t map_key(input logic [7:0] code);
    key_map_t m;
    m = '0;
    m.hit = 1'b1;
    case (code)
      SC_P1_UP:    m.idx = KEY_UP;
      SC_P1_LEFT:  m.idx = KEY_LEFT;
      SC_P1_RIGHT: m.idx = KEY_RIGHT;
      SC_P1_DOWN:  m.idx = KEY_DOWN;
      SC_P1_SHOOT: m.idx = KEY_SHOOT;
      SC_P2_UP:    begin m.p2 = 1'b1; m.idx = KEY_UP;    end
      SC_P2_LEFT:  begin m.p2 = 1'b1; m.idx = KEY_LEFT;  end
      SC_P2_RIGHT: begin m.p2 = 1'b1; m.idx = KEY_RIGHT; end
      SC_P2_DOWN:  begin m.p2 = 1'b1; m.idx = KEY_DOWN;  end
      SC_P2_SHOOT: begin m.p2 = 1'b1; m.idx = KEY_SHOOT; end
      default:     m.hit = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// ps2_frame_rx
// Synchronizes the PS/2 clock/data pins into clk, detects falling edges of
// the PS/2 clock and assembles 11-bit frames (start, 8 data LSB first, odd
// parity, stop). Frames are also aborted if the PS/2 clock stalls too long.
//
// Ports:
//   clk          system clock
//   rst_n        async active-low reset
//   keyb_clk_i   PS/2 clock pin (async)
//   kdata_i      PS/2 data pin (async)
//   byte_o       received data byte, valid while byte_stb_o is high
//   byte_stb_o   one-cycle strobe: good frame completed (combinational)
//   err_stb_o    one-cycle strobe: frame rejected or timed out (combinational)
//
// state      | meaning
// RX_IDLE    | waiting for a start bit (edge with data=0)
// RX_DATA    | shifting in the 8 data bits
// RX_PARITY  | capturing the parity bit
// RX_STOP    | checking stop bit and odd parity
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 20000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       keyb_clk_i,
  input  logic       kdata_i,
  output logic [7:0] byte_o,
  output logic       byte_stb_o,
  output logic       err_stb_o
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT_CYCLES - 1);

  logic [SYNC_STAGES-1:0] kclk_sync_q;
  logic [SYNC_STAGES-1:0] kdat_sync_q;
  logic                   kclk_hist_q;
  logic                   fall;
  logic                   dat;

  rx_state_e  state_q, state_d;
  logic [2:0] bitcnt_q, bitcnt_d;
  logic [7:0] shift_q, shift_d;
  logic       par_q, par_d;
  logic [TW-1:0] tmr_q, tmr_d;

  // Synchronizer flops reset to the idle (high) line level so reset
  // release cannot fake a falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kclk_sync_q <= '1;
      kdat_sync_q <= '1;
      kclk_hist_q <= 1'b1;
    end else begin
      kclk_sync_q <= {kclk_sync_q[SYNC_STAGES-2:0], keyb_clk_i};
      kdat_sync_q <= {kdat_sync_q[SYNC_STAGES-2:0], kdata_i};
      kclk_hist_q <= kclk_sync_q[SYNC_STAGES-1];
    end
  end

  assign fall = kclk_hist_q & ~kclk_sync_q[SYNC_STAGES-1];
  assign dat  = kdat_sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RX_IDLE;
      bitcnt_q <= '0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      tmr_q    <= TMR_LOAD;
    end else begin
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
      tmr_q    <= tmr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    bitcnt_d   = bitcnt_q;
    shift_d    = shift_q;
    par_d      = par_q;
    tmr_d      = tmr_q;
    byte_stb_o = 1'b0;
    err_stb_o  = 1'b0;

    case (state_q)
      RX_IDLE: begin
        tmr_d = TMR_LOAD;
        if (fall && !dat) begin
          state_d  = RX_DATA;
          bitcnt_d = '0;
        end
      end
      RX_DATA: begin
        if (fall) begin
          shift_d  = {dat, shift_q[7:1]};
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) state_d = RX_PARITY;
        end
      end
      RX_PARITY: begin
        if (fall) begin
          par_d   = dat;
          state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (fall) begin
          if (dat && ((^shift_q) ^ par_q)) byte_stb_o = 1'b1;
          else                             err_stb_o  = 1'b1;
          state_d = RX_IDLE;
        end
      end
      default: state_d = RX_IDLE;
    endcase

    // Inter-edge watchdog: reloads on every edge, expires at terminal count.
    // It never fires on an edge cycle, so it cannot collide with byte_stb_o.
    if (state_q != RX_IDLE) begin
      if (fall) begin
        tmr_d = TMR_LOAD;
      end else if (tmr_q == '0) begin
        err_stb_o = 1'b1;
        state_d   = RX_IDLE;
      end else begin
        tmr_d = tmr_q - 1'b1;
      end
    end
  end

  assign byte_o = shift_q;

endmodule

// File: rtl/ps2_key_controller.sv
// ps2_key_controller
// Turns validated PS/2 scan-code bytes into held-key bitmaps for two players,
// tracking E0 (extended) and F0 (break) prefixes, and counts rejected frames.
//
// Ports:
//   clk, rst_n   system clock, async active-low reset
//   keyb_clk     PS/2 clock pin (async)
//   kdata        PS/2 data pin (async)
//   p1keys       player 1 held keys {shoot, down, right, left, up}
//   p2keys       player 2 held keys, same order
//   last_code    most recent valid byte, prefixes included
//   code_valid   one-cycle pulse when last_code updates
//   frame_err    one-cycle pulse on any rejected frame
//   err_count    rejected frame count, saturating at 255
//
// state       | meaning
// D_IDLE      | next code is a make
// D_EXT       | E0 seen, next code is an extended make
// D_BREAK     | F0 seen, next code is a release
// D_EXT_BREAK | E0 F0 seen, next code is an extended release
module ps2_key_controller
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 20000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                keyb_clk,
  input  logic                kdata,
  output logic [NUM_KEYS-1:0] p1keys,
  output logic [NUM_KEYS-1:0] p2keys,
  output logic [7:0]          last_code,
  output logic                code_valid,
  output logic                frame_err,
  output logic [7:0]          err_count
);

  logic [7:0] rx_byte;
  logic       rx_stb;
  logic       rx_err;

  ps2_frame_rx #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .SYNC_STAGES    (SYNC_STAGES)
  ) u_rx (
    .clk        (clk),
    .rst_n      (rst_n),
    .keyb_clk_i (keyb_clk),
    .kdata_i    (kdata),
    .byte_o     (rx_byte),
    .byte_stb_o (rx_stb),
    .err_stb_o  (rx_err)
  );

  dec_state_e          dec_q, dec_d;
  logic [NUM_KEYS-1:0] p1_q, p1_d;
  logic [NUM_KEYS-1:0] p2_q, p2_d;
  logic [7:0]          last_q, last_d;
  logic                cv_q, cv_d;
  logic                fe_q, fe_d;
  logic [7:0]          errc_q, errc_d;
  key_map_t            km;
  logic                is_break;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_q  <= D_IDLE;
      p1_q   <= '0;
      p2_q   <= '0;
      last_q <= '0;
      cv_q   <= 1'b0;
      fe_q   <= 1'b0;
      errc_q <= '0;
    end else begin
      dec_q  <= dec_d;
      p1_q   <= p1_d;
      p2_q   <= p2_d;
      last_q <= last_d;
      cv_q   <= cv_d;
      fe_q   <= fe_d;
      errc_q <= errc_d;
    end
  end

  always_comb begin
    dec_d    = dec_q;
    p1_d     = p1_q;
    p2_d     = p2_q;
    last_d   = last_q;
    cv_d     = rx_stb;
    fe_d     = rx_err;
    errc_d   = (rx_err && errc_q != 8'hFF) ? errc_q + 8'd1 : errc_q;
    km       = map_key(rx_byte);
    is_break = (dec_q == D_BREAK) || (dec_q == D_EXT_BREAK);

    if (rx_err) begin
      // Drop any half-seen prefix sequence but keep held keys.
      dec_d = D_IDLE;
    end else if (rx_stb) begin
      last_d = rx_byte;
      if (rx_byte == SC_EXT && (dec_q == D_IDLE || dec_q == D_EXT)) begin
        dec_d = D_EXT;
      end else if (rx_byte == SC_BREAK) begin
        case (dec_q)
          D_IDLE:  dec_d = D_BREAK;
          D_EXT:   dec_d = D_EXT_BREAK;
          default: dec_d = dec_q;
        endcase
      end else if (rx_byte == SC_NUL || rx_byte == SC_OVERRUN) begin
        // Keyboard buffer overrun: key state is unknowable, release all.
        p1_d  = '0;
        p2_d  = '0;
        dec_d = D_IDLE;
      end else begin
        if (km.hit) begin
          if (km.p2) p2_d[km.idx] = ~is_break;
          else       p1_d[km.idx] = ~is_break;
        end
        dec_d = D_IDLE;
      end
    end
  end

  assign p1keys     = p1_q;
  assign p2keys     = p2_q;
  assign last_code  = last_q;
  assign code_valid = cv_q;
  assign frame_err  = fe_q;
  assign err_count  = errc_q;

endmodule

// File: tb/tb_ps2_key_controller.sv
module tb_ps2_key_controller;

  localparam int TIMEOUT_CYCLES = 300;
  localparam int SYNC_STAGES    = 2;
  localparam int HALF_NS        = 200;

  logic       clk;
  logic       rst_n;
  logic       keyb_clk;
  logic       kdata;
  logic [4:0] p1keys;
  logic [4:0] p2keys;
  logic [7:0] last_code;
  logic       code_valid;
  logic       frame_err;
  logic [7:0] err_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       is_err;
    logic [7:0] code;
    logic [4:0] p1;
    logic [4:0] p2;
  } exp_t;

  exp_t sb[$];

  ps2_key_controller #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .SYNC_STAGES    (SYNC_STAGES)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .keyb_clk   (keyb_clk),
    .kdata      (kdata),
    .p1keys     (p1keys),
    .p2keys     (p2keys),
    .last_code  (last_code),
    .code_valid (code_valid),
    .frame_err  (frame_err),
    .err_count  (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: every output pulse must match the oldest expectation.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n && (code_valid || frame_err)) begin
      checks++;
      assert (!(code_valid && frame_err)) else begin
        errors++;
        $error("FAIL pulse_excl: observed code_valid=%b frame_err=%b expected not both", code_valid, frame_err);
      end
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_pulse: observed code_valid=%b frame_err=%b last_code=%0h expected no pulse",
               code_valid, frame_err, last_code);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        checks++;
        assert (frame_err === e.is_err) else begin
          errors++;
          $error("FAIL pulse_kind: observed frame_err=%b expected %b (code %0h)", frame_err, e.is_err, e.code);
        end
        if (!e.is_err) begin
          checks++;
          assert (last_code === e.code) else begin
            errors++;
            $error("FAIL last_code: observed %0h expected %0h", last_code, e.code);
          end
        end
        checks++;
        assert (p1keys === e.p1) else begin
          errors++;
          $error("FAIL p1keys: observed %b expected %b (code %0h)", p1keys, e.p1, e.code);
        end
        checks++;
        assert (p2keys === e.p2) else begin
          errors++;
          $error("FAIL p2keys: observed %b expected %b (code %0h)", p2keys, e.p2, e.code);
        end
      end
    end
  end

  task automatic ps2_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      kdata = bits[i];
      #(HALF_NS);
      keyb_clk = 1'b0;
      #(HALF_NS);
      keyb_clk = 1'b1;
    end
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 400) begin
      @(posedge clk);
      n++;
    end
    repeat (5) @(posedge clk);
    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL drain_%s: observed %0d pending expected 0", tag, sb.size());
    end
  endtask

  task automatic push(input logic is_err, input logic [7:0] code, input logic [4:0] e1, input logic [4:0] e2);
    exp_t e;
    e.is_err = is_err;
    e.code   = code;
    e.p1     = e1;
    e.p2     = e2;
    sb.push_back(e);
  endtask

  // good_par=0 sends even parity; good_stop=0 sends a low stop bit.
  task automatic send(input logic [7:0] code, input logic good_par, input logic good_stop,
                      input logic [4:0] e1, input logic [4:0] e2, input string tag);
    logic [10:0] f;
    logic        p;
    p = good_par ? ~(^code) : (^code);
    f = {good_stop, p, code, 1'b0};
    push(!(good_par && good_stop), code, e1, e2);
    ps2_bits(f, 11);
    kdata = 1'b1;
    #(2 * HALF_NS);
    drain(tag);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_p1"},  8'(p1keys), 8'h00);
    chk({tag, "_p2"},  8'(p2keys), 8'h00);
    chk({tag, "_lc"},  last_code, 8'h00);
    chk({tag, "_cv"},  8'(code_valid), 8'h00);
    chk({tag, "_fe"},  8'(frame_err), 8'h00);
    chk({tag, "_ec"},  err_count, 8'h00);
  endtask

  initial begin
    logic [10:0] partial;
    rst_n    = 1'b0;
    keyb_clk = 1'b1;
    kdata    = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (5) @(posedge clk);

    // W make/break
    send(8'h1D, 1, 1, 5'b00000, 5'b00001, "w_make");
    send(8'hF0, 1, 1, 5'b00000, 5'b00001, "w_f0");
    send(8'h1D, 1, 1, 5'b00000, 5'b00000, "w_break");

    // Space held, then extended up make and break
    send(8'h29, 1, 1, 5'b10000, 5'b00000, "space");
    send(8'hE0, 1, 1, 5'b10000, 5'b00000, "e0_a");
    send(8'h75, 1, 1, 5'b10001, 5'b00000, "up_make");
    send(8'hE0, 1, 1, 5'b10001, 5'b00000, "e0_b");
    send(8'hF0, 1, 1, 5'b10001, 5'b00000, "f0_b");
    send(8'h75, 1, 1, 5'b10000, 5'b00000, "up_break");

    // Parity error
    send(8'h1D, 0, 1, 5'b10000, 5'b00000, "par_err");
    chk("err_count_par", err_count, 8'd1);
    chk("p2_after_par", 8'(p2keys), 8'h00);

    // Timeout: start plus 3 data bits then stall
    push(1'b1, 8'h00, 5'b10000, 5'b00000);
    partial = {3'b111, 8'h1C};
    partial = {partial[9:0], 1'b0};
    ps2_bits(partial, 4);
    kdata = 1'b1;
    repeat (TIMEOUT_CYCLES + 10) @(posedge clk);
    drain("timeout");
    chk("err_count_to", err_count, 8'd2);

    // Bad stop bit
    send(8'h1C, 1, 0, 5'b10000, 5'b00000, "stop_err");
    chk("err_count_stop", err_count, 8'd3);

    send(8'h1C, 1, 1, 5'b10000, 5'b00010, "a_make");

    // An error in the middle of a break sequence returns the decoder to make
    send(8'hF0, 1, 1, 5'b10000, 5'b00010, "f0_c");
    send(8'h55, 0, 1, 5'b10000, 5'b00010, "par_err2");
    send(8'h23, 1, 1, 5'b10000, 5'b00110, "d_make");
    chk("err_count_4", err_count, 8'd4);

    // Unmapped code leaves bitmaps alone
    send(8'h42, 1, 1, 5'b10000, 5'b00110, "unmapped");

    // Overrun clears everything
    send(8'h75, 1, 1, 5'b10001, 5'b00110, "up_hold");
    send(8'h0D, 1, 1, 5'b10001, 5'b10110, "tab_hold");
    send(8'hFF, 1, 1, 5'b00000, 5'b00000, "overrun");

    // Reset in the middle of a frame
    partial = {3'b111, 8'h75};
    partial = {partial[9:0], 1'b0};
    ps2_bits(partial, 5);
    kdata = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("midrst");
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    send(8'hF0, 1, 1, 5'b00000, 5'b00000, "post_f0");
    send(8'h29, 1, 1, 5'b00000, 5'b00000, "post_brk");
    send(8'h29, 1, 1, 5'b10000, 5'b00000, "post_make");
    chk("err_count_post", err_count, 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50ms;
    errors++;
    $display("FAIL global_timeout: observed simulation still running expected finished");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ps2_key_controller.md
# ps2_key_controller

Receives PS/2 keyboard frames in the system clock domain, validates them (start, odd parity, stop, inter-bit timeout), and runs a scan-code sequencer that tracks E0/F0 prefixes to keep a held-key bitmap for both players. Sits between the keyboard pins and the game logic and supplies `p1keys`/`p2keys`. Several keys may be held at once; release events clear only the matching bit.

## Interface
- `TIMEOUT_CYCLES`, default 20000: max `clk` cycles between falling edges inside a frame (200 µs at 100 MHz).
- `SYNC_STAGES`, default 2: synchronizer depth for `keyb_clk` and `kdata`, minimum 2.
- `clk`  in  1: onboard system clock. All logic is on its rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `keyb_clk`  in  1: PS/2 clock pin, asynchronous to `clk`.
- `kdata`  in  1: PS/2 data pin, asynchronous to `clk`.
- `p1keys`  out  5: held keys for player 1. Bit 0 up, 1 left, 2 right, 3 down, 4 shoot.
- `p2keys`  out  5: held keys for player 2, using the same bit order.
- `last_code`  out  8: most recent valid byte, including prefixes.
- `code_valid`  out  1: one-cycle pulse when `last_code` updates.
- `frame_err`  out  1: one-cycle pulse on any rejected frame.
- `err_count`  out  8: count of rejected frames, saturating at 255.

## Operation
- **Synchronizer**
  - `SYNC_STAGES` flops per pin, plus one history flop on the clock path.
  - All flops reset to 1, which is the idle line level.
  - A falling edge is history=1 and sync=0. Data is sampled from synchronized `kdata` in the edge cycle.
- **Frame FSM: states RX_IDLE, RX_DATA, RX_PARITY, RX_STOP**
  - RX_IDLE: on an edge with data=0 (start bit), clear `bitcnt` and go to RX_DATA. An edge with data=1 is ignored.
  - RX_DATA: shift in LSB first, 8 edges. After the 8th edge go to RX_PARITY.
  - RX_PARITY: store the parity bit and go to RX_STOP.
  - RX_STOP: on the edge, the frame is good only if data=1 and the XOR of the 8 data bits and the parity bit is 1. Good frames produce a byte strobe; bad frames raise `frame_err`. Return to RX_IDLE in either case.
  - Timeout: the counter runs in any non-idle state and clears on every edge. Reaching `TIMEOUT_CYCLES`-1 raises `frame_err` and returns to RX_IDLE.
- **Decode FSM: states D_IDLE, D_EXT, D_BREAK, D_EXT_BREAK** (one step per byte strobe)
  - 0xE0 in D_IDLE goes to D_EXT.
  - 0xF0 in D_IDLE goes to D_BREAK; 0xF0 in D_EXT goes to D_EXT_BREAK.
  - Any other byte is a code:
    - In D_IDLE or D_EXT it is a make: set the mapped bit.
    - In D_BREAK or D_EXT_BREAK it is a break: clear the mapped bit.
    - The FSM then returns to D_IDLE.
  - A repeated prefix (E0 in D_EXT, F0 in a break state) leaves the state unchanged.
  - `frame_err` forces D_IDLE. Key bits are kept.
- **Key map** (code only; the E0 flag does not affect mapping)
  - Player 1: 0x75 up, 0x6B left, 0x74 right, 0x72 down, 0x29 space = shoot.
  - Player 2: 0x1D W = up, 0x1C A = left, 0x23 D = right, 0x1B S = down, 0x0D Tab = shoot.
  - Codes 0x00 and 0xFF (keyboard overrun) clear both bitmaps and return to D_IDLE.
  - Other codes leave the bitmaps unchanged.
- **Error counter**: `err_count` increments on every `frame_err` pulse and saturates at 255.

## Timing
- **Reset**: all outputs are 0, both FSMs idle, counters 0.
- **Edge detection latency**: a pin falling edge is detected `SYNC_STAGES`+1 cycles later (call this cycle E).
- **Good frame**: stop edge detected at cycle E. At E+1, `code_valid`=1, `last_code` is updated, and `p1keys`/`p2keys` show the new bitmap. All change in the same cycle.
- **Bad frame**:
  - Stop/parity failure at cycle E gives `frame_err`=1 at E+1.
  - Timeout expiry at cycle T gives `frame_err`=1 at T+1.
  - `code_valid` stays 0 and the bitmaps do not change.
- **Pulse exclusivity**: `code_valid` and `frame_err` are never high in the same cycle.
- **Throughput**: no back-pressure. Consecutive frames are at least 11 PS/2 clock edges apart, so no buffering is needed.
- **Reset mid-frame**: the partial byte is discarded; the next frame decodes normally.

## Structure
- **Package `ps2_pkg`**:
  - Scan-code constants: E0, F0, the ten mapped keys, 00 and FF.
  - Key bit indices: UP=0, LEFT=1, RIGHT=2, DOWN=3, SHOOT=4.
  - Enums for both FSMs.
- **Sub-module `ps2_frame_rx`**:
  - Contains the synchronizer, frame FSM and timeout.
  - Outputs `byte`, `byte_stb` and `err_stb`.
- **Top**: `ps2_key_controller` contains the decode FSM, key bitmaps and error counter.

## Test plan
- Make/break of W: send 1D, then F0 1D. Expect `p2keys`=00001 after the first byte and 00000 after the break. `code_valid` pulses 3 times with `last_code` sequence 1D, F0, 1D.
- Extended arrow plus a held key: send 29, then E0 75. Expect `p1keys`=10001. Then send E0 F0 75. Expect `p1keys`=10000.
- Parity error: send 0x1D with even parity. Expect `frame_err` pulse, `err_count`=1, `p2keys` unchanged, no `code_valid`.
- Timeout: send start plus 3 data bits, then stall for `TIMEOUT_CYCLES`+10 cycles. Expect one `frame_err`. A following good 0x1C frame gives `p2keys`=00010.
- Overrun: hold up and Tab, then send FF. Expect both bitmaps = 00000.
- Reset mid-frame: drop `rst_n` after 4 data bits. Expect all outputs 0. The next good F0 29 gives no bitmap change and leaves the decode FSM in D_IDLE.
